dport_axi4lite_bridge: RTL and testbench



---
 rtl/dport_axi4lite_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_dport_axi4lite_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dport_axi4lite_bridge.sv
// dport_axi4lite_bridge
// CPU data-port (request/accept, tagged ack) to single AXI4-Lite master.
// Up to MAX_OUTSTANDING in-order transactions, all of one type (read or
// write) at a time. Request tags ride alongside in a small FIFO and come
// back with each ack.
// Optional build macro: DPORT_AXI4LITE_ALIGN_CHECK_EN
//   defined   : misaligned requests get an immediate error ack, no AXI traffic
//   undefined : low address bits are masked and the access proceeds
module dport_axi4lite_bridge #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_wr_i,
  input  logic             mem_rd_i,
  input  logic [3:0]       mem_wr_i,
  input  logic [TAG_W-1:0] mem_req_tag_i,
  output logic             mem_accept_o,
  output logic             mem_ack_o,
  output logic [31:0]      mem_data_rd_o,
  output logic             mem_error_o,
  output logic [TAG_W-1:0] mem_resp_tag_o,
  output logic             outport_awvalid_o,
  output logic [31:0]      outport_awaddr_o,
  input  logic             outport_awready_i,
  output logic             outport_wvalid_o,
  output logic [31:0]      outport_wdata_o,
  output logic [3:0]       outport_wstrb_o,
  input  logic             outport_wready_i,
  input  logic             outport_bvalid_i,
  input  logic [1:0]       outport_bresp_i,
  output logic             outport_bready_o,
  output logic             outport_arvalid_o,
  output logic [31:0]      outport_araddr_o,
  input  logic             outport_arready_i,
  input  logic             outport_rvalid_i,
  input  logic [31:0]      outport_rdata_i,
  input  logic [1:0]       outport_rresp_i,
  output logic             outport_rready_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // Channel flags and payload registers
  logic             aw_pend_q, w_pend_q, ar_pend_q;
  logic             aw_pend_d, w_pend_d, ar_pend_d;
  logic [31:0]      awaddr_q, wdata_q, araddr_q;
  logic [3:0]       wstrb_q;

  // Outstanding count and tag FIFO; entry = {tag, is_write}
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_W:0]   fifo_q [MAX_OUTSTANDING];
  logic [TAG_W:0]   head;

  // Registered response
  logic             ack_q;
  logic             err_q;
  logic [31:0]      data_q;
  logic [TAG_W-1:0] tag_q;

  logic             req_wr, req_valid, chan_busy, type_ok, misalign;
  logic             do_accept, push, pop;
  logic [31:0]      addr_aligned;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign req_wr       = |mem_wr_i;
  assign req_valid    = req_wr | mem_rd_i;
  assign addr_aligned = mem_addr_i & 32'hFFFF_FFFC;
  assign chan_busy    = aw_pend_q | w_pend_q | ar_pend_q;
  assign head         = fifo_q[rd_ptr_q];
  // The FIFO head holds the type of every in-flight transaction, since
  // only one type is allowed in flight at a time.
  assign type_ok      = (outstanding_q == '0) || (head[0] == req_wr);

`ifdef DPORT_AXI4LITE_ALIGN_CHECK_EN
  assign misalign     = |mem_addr_i[1:0];
  assign mem_accept_o = !chan_busy && (outstanding_q < CNT_MAX) && type_ok &&
                        (!misalign || (outstanding_q == '0));
`else
  assign misalign     = 1'b0;
  assign mem_accept_o = !chan_busy && (outstanding_q < CNT_MAX) && type_ok;
`endif

  assign do_accept = req_valid & mem_accept_o;
  assign push      = do_accept & ~misalign;
  // Write response wins if both arrive together; responses with nothing
  // outstanding are swallowed.
  assign pop       = (outport_bvalid_i | outport_rvalid_i) && (outstanding_q != '0);

  // Next-state for channel flags, counter and FIFO pointers
  always_comb begin
    aw_pend_d     = aw_pend_q;
    w_pend_d      = w_pend_q;
    ar_pend_d     = ar_pend_q;
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (aw_pend_q && outport_awready_i) aw_pend_d = 1'b0;
    if (w_pend_q && outport_wready_i)   w_pend_d  = 1'b0;
    if (ar_pend_q && outport_arready_i) ar_pend_d = 1'b0;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (req_wr) begin
        aw_pend_d = 1'b1;
        w_pend_d  = 1'b1;
      end else begin
        ar_pend_d = 1'b1;
      end
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state: flags, counter, pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      ar_pend_q     <= 1'b0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      ar_pend_q     <= ar_pend_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Request payload capture; only loaded on accept so it holds while valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      araddr_q <= '0;
    end else if (push) begin
      if (req_wr) begin
        awaddr_q <= addr_aligned;
        wdata_q  <= mem_data_wr_i;
        wstrb_q  <= mem_wr_i;
      end else begin
        araddr_q <= addr_aligned;
      end
    end
  end

  // Tag FIFO storage; validity is tracked by the pointers/counter
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {mem_req_tag_i, req_wr};
  end

  // Response register: one-cycle ack pulse with tag, data and error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      if (pop) begin
        ack_q <= 1'b1;
        tag_q <= head[TAG_W:1];
        if (outport_bvalid_i) begin
          err_q  <= (outport_bresp_i != 2'b00);
          data_q <= '0;
        end else begin
          err_q  <= (outport_rresp_i != 2'b00);
          data_q <= outport_rdata_i;
        end
      end else if (do_accept && misalign) begin
        ack_q  <= 1'b1;
        tag_q  <= mem_req_tag_i;
        err_q  <= 1'b1;
        data_q <= '0;
      end
    end
  end

  assign outport_awvalid_o = aw_pend_q;
  assign outport_awaddr_o  = awaddr_q;
  assign outport_wvalid_o  = w_pend_q;
  assign outport_wdata_o   = wdata_q;
  assign outport_wstrb_o   = wstrb_q;
  assign outport_arvalid_o = ar_pend_q;
  assign outport_araddr_o  = araddr_q;
  assign outport_bready_o  = 1'b1;
  assign outport_rready_o  = 1'b1;

  assign mem_ack_o      = ack_q;
  assign mem_error_o    = err_q;
  assign mem_data_rd_o  = data_q;
  assign mem_resp_tag_o = tag_q;

endmodule

// File: tb/tb_dport_axi4lite_bridge.sv
// Directed bench for dport_axi4lite_bridge (default build, MAX_OUTSTANDING=2).
// The AXI slave side is driven by hand, cycle by cycle.
module tb_dport_axi4lite_bridge;

  localparam int TAG_W = 11;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [31:0]      mem_addr_i = '0;
  logic [31:0]      mem_data_wr_i = '0;
  logic             mem_rd_i = 1'b0;
  logic [3:0]       mem_wr_i = '0;
  logic [TAG_W-1:0] mem_req_tag_i = '0;
  logic             mem_accept_o, mem_ack_o, mem_error_o;
  logic [31:0]      mem_data_rd_o;
  logic [TAG_W-1:0] mem_resp_tag_o;
  logic             awvalid, awready = 1'b0;
  logic [31:0]      awaddr;
  logic             wvalid, wready = 1'b0;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             bvalid = 1'b0, bready;
  logic [1:0]       bresp = 2'b00;
  logic             arvalid, arready = 1'b0;
  logic [31:0]      araddr;
  logic             rvalid = 1'b0, rready;
  logic [31:0]      rdata = '0;
  logic [1:0]       rresp = 2'b00;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  dport_axi4lite_bridge #(.MAX_OUTSTANDING(2), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_req_tag_i(mem_req_tag_i),
    .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o),
    .mem_data_rd_o(mem_data_rd_o), .mem_error_o(mem_error_o),
    .mem_resp_tag_o(mem_resp_tag_o),
    .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awready_i(awready),
    .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
    .outport_wready_i(wready),
    .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bready_o(bready),
    .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arready_i(arready),
    .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
    .outport_rready_o(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req_read(input logic [31:0] a, input logic [TAG_W-1:0] t);
    mem_addr_i = a; mem_rd_i = 1'b1; mem_wr_i = '0; mem_req_tag_i = t;
  endtask

  task automatic req_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [TAG_W-1:0] t);
    mem_addr_i = a; mem_data_wr_i = d; mem_wr_i = s; mem_rd_i = 1'b0; mem_req_tag_i = t;
  endtask

  task automatic req_none();
    mem_rd_i = 1'b0; mem_wr_i = '0;
  endtask

  task automatic check_ack(input string tag, input logic [TAG_W-1:0] t,
                           input logic [31:0] d, input logic e);
    check({tag, "_ack"}, mem_ack_o, 1'b1);
    check({tag, "_tag"}, mem_resp_tag_o, t);
    check({tag, "_data"}, mem_data_rd_o, d);
    check({tag, "_err"}, mem_error_o, e);
  endtask

  initial begin
    // ---------------- reset values ----------------
    #1;
    check("rst_accept_during", mem_accept_o, 1'b1);
    tick(); tick();
    rst_i = 1'b0;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_ack", mem_ack_o, 1'b0);
    check("rst_bready", bready, 1'b1);
    check("rst_rready", rready, 1'b1);
    check("rst_accept", mem_accept_o, 1'b1);

    // ---------------- T1: single read, zero-wait slave ----------------
    req_read(32'h9200_0000, 11'd5);
    #1 check("t1_accept", mem_accept_o, 1'b1);
    tick();                                   // cycle 1: accepted
    req_none();
    check("t1_arvalid", arvalid, 1'b1);
    check("t1_araddr", araddr, 32'h9200_0000);
    check("t1_ack_c1", mem_ack_o, 1'b0);
    arready = 1'b1;
    tick();                                   // cycle 2: AR handshake done
    arready = 1'b0;
    check("t1_arvalid_drop", arvalid, 1'b0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    tick();                                   // cycle 3: ack
    rvalid = 1'b0;
    check_ack("t1", 11'd5, 32'hDEAD_BEEF, 1'b0);
    tick();
    check("t1_ack_pulse", mem_ack_o, 1'b0);

    // ---------------- T2: write, W two cycles before AW ----------------
    req_write(32'h9300_0004, 32'h1234_5678, 4'b0011, 11'd7);
    tick();
    req_none();
    check("t2_awvalid", awvalid, 1'b1);
    check("t2_wvalid", wvalid, 1'b1);
    check("t2_awaddr", awaddr, 32'h9300_0004);
    check("t2_wdata", wdata, 32'h1234_5678);
    check("t2_wstrb", wstrb, 4'b0011);
    check("t2_accept_busy", mem_accept_o, 1'b0);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    check("t2_wvalid_drop", wvalid, 1'b0);
    check("t2_awvalid_hold", awvalid, 1'b1);
    tick();
    check("t2_awaddr_stable", awaddr, 32'h9300_0004);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check("t2_awvalid_drop", awvalid, 1'b0);
    check("t2_no_early_ack", mem_ack_o, 1'b0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    check_ack("t2", 11'd7, 32'h0, 1'b0);
    tick();
    check("t2_single_ack", mem_ack_o, 1'b0);

    // ---------------- T3: two reads in flight, third held ----------------
    req_read(32'h9200_0010, 11'd1);
    tick();                                   // tag1 accepted
    req_read(32'h9200_0014, 11'd2);
    arready = 1'b1;
    #1 check("t3_accept_arpend", mem_accept_o, 1'b0);
    tick();                                   // AR for tag1
    check("t3_accept_second", mem_accept_o, 1'b1);
    tick();                                   // tag2 accepted
    req_read(32'h9200_0018, 11'd3);
    check("t3_araddr2", araddr, 32'h9200_0014);
    tick();                                   // AR for tag2
    check("t3_accept_full", mem_accept_o, 1'b0);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick();                                   // pop tag1
    check_ack("t3a", 11'd1, 32'h1111_1111, 1'b0);
    check("t3_accept_after_ack", mem_accept_o, 1'b1);
    rdata = 32'h2222_2222;
    tick();                                   // pop tag2, accept tag3
    check_ack("t3b", 11'd2, 32'h2222_2222, 1'b0);
    rvalid = 1'b0;
    req_none();
    check("t3_araddr3", araddr, 32'h9200_0018);
    tick();                                   // AR for tag3
    arready = 1'b0;
    check("t3_no_ack_gap", mem_ack_o, 1'b0);
    rvalid = 1'b1; rdata = 32'h3333_3333;
    tick();
    rvalid = 1'b0;
    check_ack("t3c", 11'd3, 32'h3333_3333, 1'b0);

    // ---------------- T4/T5: read in flight blocks write; bresp error ----------------
    tick();
    req_read(32'h9200_0020, 11'd9);
    tick();
    // rd and wr both set: treated as a write
    req_write(32'h9300_0008, 32'hA5A5_5A5A, 4'hF, 11'd10);
    mem_rd_i = 1'b1;
    arready = 1'b1;
    #1 check("t4_accept_arpend", mem_accept_o, 1'b0);
    tick();
    arready = 1'b0;
    check("t4_accept_mixed", mem_accept_o, 1'b0);
    tick();
    check("t4_accept_mixed2", mem_accept_o, 1'b0);
    rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    rvalid = 1'b0;
    check_ack("t4", 11'd9, 32'h0BAD_F00D, 1'b0);
    check("t4_accept_write", mem_accept_o, 1'b1);
    tick();                                   // write accepted
    req_none();
    check("t4_awvalid", awvalid, 1'b1);
    check("t4_arvalid", arvalid, 1'b0);
    check("t4_awaddr", awaddr, 32'h9300_0008);
    awready = 1'b1; wready = 1'b1;
    tick();                                   // AW and W together
    awready = 1'b0; wready = 1'b0;
    check("t4_aw_done", awvalid, 1'b0);
    check("t4_w_done", wvalid, 1'b0);
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check_ack("t5", 11'd10, 32'h0, 1'b1);

    // ---------------- T6: reset with AW pending ----------------
    tick();
    req_write(32'h9300_000C, 32'h5555_AAAA, 4'hF, 11'd12);
    tick();
    req_none();
    check("t6_awvalid_pre", awvalid, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_awvalid_async", awvalid, 1'b0);
    check("t6_wvalid_async", wvalid, 1'b0);
    check("t6_accept_in_rst", mem_accept_o, 1'b1);
    tick();
    rst_i = 1'b0;
    bvalid = 1'b1;                            // late response, nothing outstanding
    tick();
    bvalid = 1'b0;
    check("t6_no_ack1", mem_ack_o, 1'b0);
    tick();
    check("t6_no_ack2", mem_ack_o, 1'b0);
    // low address bits masked in the default build
    req_read(32'h9200_0022, 11'd4);
    tick();
    req_none();
    check("t6_araddr_masked", araddr, 32'h9200_0020);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    rvalid = 1'b0;
    check_ack("t6", 11'd4, 32'hCAFE_F00D, 1'b0);
    tick();
    check("t6_idle_accept", mem_accept_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
